// File: rtl/xbuf_mem_ctrl.sv
// xbuf_mem_ctrl: burst controller between a request/stream interface and a
// single-port memory that has a shared bidirectional data bus.
// Write bursts stream one word per wr_valid cycle. Read bursts issue one
// address per rd_ready cycle. The memory returns each read word on mem_data
// in the cycle after the issue, and the controller registers it into rd_data.
module xbuf_mem_ctrl #(
   parameter int MEM_WIDTH  = 256,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [MEM_WIDTH-1:0]  wr_data,
   input  logic                  rd_ready,
   output logic                  rd_valid,
   output logic [MEM_WIDTH-1:0]  rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   inout  wire  [MEM_WIDTH-1:0]  mem_data
);

   // Every memory word covers 32 bytes, so each beat steps the address by 32.
   // The addition is ADDR_WIDTH bits wide and wraps at the top of the space.
   localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(32);
   localparam logic [LEN_WIDTH-1:0]  ONE_WORD   = LEN_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [LEN_WIDTH-1:0]  remaining;
   logic                  pend;       // a read was issued in the previous cycle

   logic write_fire;
   logic read_fire;
   logic req_bad;

   assign write_fire = (state == WRITE) && wr_valid;
   assign read_fire  = (state == READ)  && rd_ready;
   assign req_bad    = (req_len == '0) || (req_addr[4:0] != 5'd0);

   assign req_ready = (state == IDLE);
   assign wr_ready  = (state == WRITE);
   assign busy      = (state != IDLE);

   // The controller drives the shared bus only while it is writing.
   assign mem_data = (mem_cs && mem_we) ? wr_data : 'z;

   // Memory command decode: a beat goes out in the same cycle it is offered.
   always_comb begin
      // NOTE: every output gets a default before the branches so that no path
      // leaves it unassigned, which would infer a latch.
      mem_cs   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      if (write_fire) begin
         mem_cs   = 1'b1;
         mem_we   = 1'b1;
         mem_addr = addr;
      end else if (read_fire) begin
         mem_cs   = 1'b1;
         mem_addr = addr;
      end
   end

   // Burst sequencer, address/length counters and read-return capture.
   always_ff @(posedge clock) begin
      // NOTE: state is updated with non-blocking assignments so that every
      // right-hand side sees the values from before this edge.
      if (reset) begin
         // NOTE: clearing pend here discards any read that is still in flight,
         // so an aborted burst produces no late rd_valid.
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         pend      <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done     <= 1'b0;
         err      <= 1'b0;
         pend     <= 1'b0;
         rd_valid <= pend;
         if (pend) begin
            rd_data <= mem_data;
         end

         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (req_bad) begin
                     err <= 1'b1;
                  end else begin
                     addr      <= req_addr;
                     remaining <= req_len;
                     state     <= req_write ? WRITE : READ;
                  end
               end
            end

            WRITE: begin
               if (wr_valid) begin
                  addr      <= addr + WORD_BYTES;
                  remaining <= remaining - ONE_WORD;
                  if (remaining == ONE_WORD) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
            end

            READ: begin
               if (rd_ready) begin
                  addr      <= addr + WORD_BYTES;
                  remaining <= remaining - ONE_WORD;
                  pend      <= 1'b1;
                  if (remaining == ONE_WORD) begin
                     state <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               // The final word is captured on this edge, so done lines up
               // with the last rd_valid.
               done  <= 1'b1;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xbuf_mem_ctrl.sv
// Testbench for xbuf_mem_ctrl. A small synchronous memory model sits on the
// mem_* bus. It stores writes and returns read data one cycle after the read
// command. The reference model keeps the expected memory contents as a plain
// array and builds the expected read returns as a queue.
module tb_xbuf_mem_ctrl;

   localparam int MW = 256;
   localparam int AW = 32;
   localparam int LW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [LW-1:0] req_len = '0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [MW-1:0] wr_data = '0;
   logic          rd_ready = 1'b0;
   logic          rd_valid;
   logic [MW-1:0] rd_data;
   logic          busy;
   logic          done;
   logic          err;
   logic          mem_cs;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   wire  [MW-1:0] mem_data;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int            due;
      logic [MW-1:0] data;
   } resp_t;

   // Memory device on the bus, plus the bench's own record of expected contents.
   logic [MW-1:0] dev_mem   [256];
   logic [MW-1:0] model_mem [256];
   logic          drv_en  = 1'b0;
   logic [MW-1:0] drv_val = '0;

   assign mem_data = drv_en ? drv_val : 'z;

   xbuf_mem_ctrl #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
      .busy(busy), .done(done), .err(err),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data)
   );

   always #5 clock = ~clock;

   function automatic int idx(input logic [AW-1:0] a);
      return int'(a[12:5]);
   endfunction

   function automatic logic [MW-1:0] fill(input int i);
      return {8{32'hC0DE_0000 | 32'(i)}};
   endfunction

   function automatic logic [MW-1:0] rand_word();
      logic [MW-1:0] w;
      for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // Synchronous memory: write on the edge, read data on the bus next cycle.
   always @(posedge clock) begin
      if (mem_cs && mem_we) dev_mem[idx(mem_addr)] <= mem_data;
      drv_en  <= mem_cs && !mem_we;
      drv_val <= dev_mem[idx(mem_addr)];
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input int len, input bit gaps);
      int k = 0;
      int cyc = 0;
      logic [AW-1:0] ea;
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = LW'(len);
      @(negedge clock);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL wr_req_ready: got %b expected 1", req_ready);
      end
      tick();
      req_valid = 1'b0; req_addr = $urandom; req_len = LW'($urandom);
      while (k < len && cyc < 4000) begin
         wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         wr_data  = rand_word();
         rd_ready = 1'($urandom_range(0, 1));
         ea = a + 32'(32 * k);
         @(negedge clock);
         checks++;
         if ({wr_ready, busy, req_ready, done} !== 4'b1100) begin
            failures++;
            $display("FAIL wr_status: got wr_ready/busy/req_ready/done=%b expected 1100",
                     {wr_ready, busy, req_ready, done});
         end
         checks++;
         if (wr_valid) begin
            if ({mem_cs, mem_we} !== 2'b11 || mem_addr !== ea || mem_data !== wr_data) begin
               failures++;
               $display("FAIL wr_beat: got cs/we=%b addr=%h data=%h expected 11 addr=%h data=%h",
                        {mem_cs, mem_we}, mem_addr, mem_data, ea, wr_data);
            end
            model_mem[idx(ea)] = wr_data;
            k++;
         end else if ({mem_cs, mem_we} !== 2'b00 || mem_addr !== '0) begin
            failures++;
            $display("FAIL wr_idle_beat: got cs/we=%b addr=%h expected 00 addr=0",
                     {mem_cs, mem_we}, mem_addr);
         end
         tick();
         cyc++;
      end
      wr_valid = 1'b0;
      if (k < len) begin
         checks++; failures++;
         $display("FAIL wr_timeout: got %0d words expected %0d", k, len);
      end
      @(negedge clock);
      checks++;
      if ({done, busy, req_ready, wr_ready} !== 4'b1010) begin
         failures++;
         $display("FAIL wr_done: got done/busy/req_ready/wr_ready=%b expected 1010",
                  {done, busy, req_ready, wr_ready});
      end
      tick();
   endtask

   // mode 0: rd_ready held high, 1: random, 2: LSB-first pattern then high.
   task automatic do_read(input logic [AW-1:0] a, input int len, input int mode,
                          input logic [31:0] pat);
      resp_t q[$];
      int issued = 0;
      int got = 0;
      int cyc = 0;
      bit exp_issue, exp_rdv, last;
      logic [AW-1:0] ea;
      req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = LW'(len);
      @(negedge clock);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL rd_req_ready: got %b expected 1", req_ready);
      end
      tick();
      req_valid = 1'b0; req_addr = $urandom; req_len = LW'($urandom);
      while (got < len && cyc < 4000) begin
         case (mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = 1'($urandom_range(0, 1));
            default: rd_ready = (cyc < 32) ? pat[cyc] : 1'b1;
         endcase
         wr_valid = 1'($urandom_range(0, 1));
         ea = a + 32'(32 * issued);
         @(negedge clock);
         exp_issue = (issued < len) && rd_ready;
         checks++;
         if (mem_cs !== exp_issue || mem_we !== 1'b0 || wr_ready !== 1'b0 ||
             mem_addr !== (exp_issue ? ea : '0)) begin
            failures++;
            $display("FAIL rd_issue: cyc=%0d got cs=%b we=%b wr_ready=%b addr=%h expected cs=%b we=0 wr_ready=0 addr=%h",
                     cyc, mem_cs, mem_we, wr_ready, mem_addr, exp_issue, exp_issue ? ea : '0);
         end
         exp_rdv = (q.size() > 0) && (q[0].due == cyc);
         last    = exp_rdv && (got == len - 1);
         checks++;
         if (rd_valid !== exp_rdv || done !== last || busy !== !last) begin
            failures++;
            $display("FAIL rd_status: cyc=%0d got rd_valid/done/busy=%b%b%b expected %b%b%b",
                     cyc, rd_valid, done, busy, exp_rdv, last, !last);
         end
         if (exp_rdv) begin
            checks++;
            if (rd_data !== q[0].data) begin
               failures++;
               $display("FAIL rd_data: got %h expected %h", rd_data, q[0].data);
            end
            void'(q.pop_front());
            got++;
         end
         if (exp_issue) begin
            q.push_back('{due: cyc + 2, data: model_mem[idx(ea)]});
            issued++;
         end
         tick();
         cyc++;
      end
      rd_ready = 1'b0; wr_valid = 1'b0;
      if (got < len) begin
         checks++; failures++;
         $display("FAIL rd_timeout: got %0d words expected %0d", got, len);
      end
      @(negedge clock);
      checks++;
      if ({rd_valid, done, busy, req_ready} !== 4'b0001) begin
         failures++;
         $display("FAIL rd_end: got rd_valid/done/busy/req_ready=%b expected 0001",
                  {rd_valid, done, busy, req_ready});
      end
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b1; wr_valid = 1'b1; rd_ready = 1'b1;
      tick();
      tick();
      @(negedge clock);
      checks++;
      if ({rd_valid, done, err, busy, mem_cs, mem_we} !== 6'b0 || mem_addr !== '0 ||
          rd_data !== '0) begin
         failures++;
         $display("FAIL reset_state: got rd_valid/done/err/busy/cs/we=%b addr=%h rd_data=%h expected all zero",
                  {rd_valid, done, err, busy, mem_cs, mem_we}, mem_addr, rd_data);
      end
      tick();
      reset = 1'b0; req_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
      @(negedge clock);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL reset_req_ready: got %b expected 1", req_ready);
      end
      tick();
   endtask

   task automatic test_reject();
      logic [AW-1:0] bad_addr [3];
      logic [LW-1:0] bad_len  [3];
      bad_addr[0] = 32'h0000_0044; bad_len[0] = 8'd3;
      bad_addr[1] = 32'h0000_0040; bad_len[1] = 8'd0;
      bad_addr[2] = $urandom;      bad_len[2] = LW'($urandom_range(1, 255));
      bad_addr[2][4:0] = 5'($urandom_range(1, 31));
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1; req_write = 1'($urandom_range(0, 1));
         req_addr = bad_addr[i]; req_len = bad_len[i];
         @(negedge clock);
         checks++;
         if ({req_ready, mem_cs, err} !== 3'b100) begin
            failures++;
            $display("FAIL reject_req: case %0d got req_ready/cs/err=%b expected 100",
                     i, {req_ready, mem_cs, err});
         end
         tick();
         req_valid = 1'b0;
         @(negedge clock);
         checks++;
         if ({err, busy, req_ready, mem_cs} !== 4'b1010) begin
            failures++;
            $display("FAIL reject_err: case %0d got err/busy/req_ready/cs=%b expected 1010",
                     i, {err, busy, req_ready, mem_cs});
         end
         tick();
         @(negedge clock);
         checks++;
         if ({err, busy} !== 2'b00) begin
            failures++;
            $display("FAIL reject_pulse: case %0d got err/busy=%b expected 00", i, {err, busy});
         end
         tick();
      end
   endtask

   task automatic test_basic();
      do_write(32'h0000_0040, 3, 1'b0);
      do_read(32'h0000_0040, 3, 0, 32'h0);
   endtask

   task automatic test_toggle();
      do_read(32'h0000_0040, 4, 2, 32'b101101);
   endtask

   task automatic test_wrap();
      do_write(32'hFFFF_FFE0, 2, 1'b0);
      do_read(32'hFFFF_FFE0, 2, 0, 32'h0);
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      int len;
      for (int i = 0; i < 8; i++) begin
         a   = {19'b0, 8'($urandom), 5'b0};
         len = $urandom_range(1, 20);
         do_write(a, len, 1'b1);
         do_read(a, len, 1, 32'h0);
      end
   endtask

   task automatic test_max_len();
      do_write(32'h0000_0800, 255, 1'b0);
      do_read(32'h0000_0800, 255, 0, 32'h0);
   endtask

   task automatic test_reset_mid_burst();
      logic [AW-1:0] a = 32'h0000_0200;
      req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = 8'd5;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rd_ready = 1'b1;
         @(negedge clock);
         checks++;
         if (mem_cs !== 1'b1 || mem_addr !== a + 32'(32 * i)) begin
            failures++;
            $display("FAIL abort_issue: %0d got cs=%b addr=%h expected cs=1 addr=%h",
                     i, mem_cs, mem_addr, a + 32'(32 * i));
         end
         tick();
      end
      rd_ready = 1'b0; reset = 1'b1;
      @(negedge clock);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== model_mem[idx(a)]) begin
         failures++;
         $display("FAIL abort_first_word: got rd_valid=%b data=%h expected 1 data=%h",
                  rd_valid, rd_data, model_mem[idx(a)]);
      end
      tick();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rd_ready = 1'b1;
         @(negedge clock);
         checks++;
         if ({rd_valid, done, busy, mem_cs, req_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL abort_quiet: cyc %0d got rd_valid/done/busy/cs/req_ready=%b expected 00001",
                     i, {rd_valid, done, busy, mem_cs, req_ready});
         end
         tick();
      end
      rd_ready = 1'b0;
      do_write(a, 2, 1'b0);
      do_read(a, 2, 0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         dev_mem[i]   = fill(i);
         model_mem[i] = fill(i);
      end
      test_reset();
      test_basic();
      test_toggle();
      test_reject();
      test_wrap();
      test_random();
      test_max_len();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xbuf_mem_ctrl.md
XBUF_MEM_CTRL -- requirements
Module: xbuf_mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 256, memory word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, burst-length field width.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports clock and reset.
REQ-005 SHALL have ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  burst request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_WIDTH  start byte address.
- req_len  in  LEN_WIDTH  number of words in the burst.
- wr_valid  in  1  write word present.
- wr_ready  out  1  write word consumed.
- wr_data  in  MEM_WIDTH  write word.
- rd_ready  in  1  consumer can take one more read word.
- rd_valid  out  1  read word valid, single-cycle, no backpressure.
- rd_data  out  MEM_WIDTH  read word.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.
- err  out  1  one-cycle pulse when a request is rejected.
- mem_cs  out  1  memory chip select.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory byte address.
- mem_data  inout  MEM_WIDTH  memory data bus.

Function
REQ-006 SHALL implement the states IDLE, WRITE, READ and DRAIN.
REQ-007 SHALL drive req_ready=1 only in IDLE.
REQ-008 SHALL treat a request as accepted when req_valid and req_ready are both 1 on a rising edge.
REQ-009 SHALL reject a request with req_len=0 or req_addr[4:0]!=0: err=1 for the next cycle, remain in IDLE, no memory access.
REQ-010 On a valid accept, SHALL latch addr=req_addr and remaining=req_len, and go to WRITE (req_write=1) or READ (req_write=0).
REQ-011 In WRITE, SHALL drive wr_ready=1.
REQ-012 In WRITE, each cycle with wr_valid=1 SHALL combinationally drive mem_cs=1, mem_we=1, mem_addr=addr and mem_data=wr_data.
REQ-013 In WRITE, each such cycle SHALL advance addr by 32 and decrement remaining by 1.
REQ-014 In WRITE, a cycle with wr_valid=0 SHALL drive mem_cs=0 and leave addr and remaining unchanged.
REQ-015 In WRITE, when the last word is accepted (remaining==1), SHALL return to IDLE and pulse done on the next cycle.
REQ-016 In READ, each cycle with rd_ready=1 SHALL drive mem_cs=1, mem_we=0, mem_addr=addr.
REQ-017 In READ, each such issue SHALL advance addr by 32, decrement remaining and set the registered flag pend=1.
REQ-018 In READ, a cycle with rd_ready=0 SHALL issue nothing and set pend=0.
REQ-019 Read latency SHALL be fixed at 1: when pend=1, mem_data SHALL be sampled into rd_data on the following edge and rd_valid=1 asserted for one cycle.
REQ-020 Read words SHALL be returned in issue order.
REQ-021 After the last read issue, SHALL go to DRAIN, capture the final word, pulse done in the same cycle as the final rd_valid, then return to IDLE.
REQ-022 SHALL drive mem_data only when mem_cs=1 and mem_we=1, and high-impedance otherwise.
REQ-023 When mem_cs=0, SHALL drive mem_we=0 and mem_addr=0.
REQ-024 addr SHALL increment modulo 2^ADDR_WIDTH, so the burst wraps from 0xFFFFFFE0 to 0x00000000 with no error.
REQ-025 SHALL drive busy=1 in every state other than IDLE.
REQ-026 SHALL ignore wr_valid outside WRITE, with wr_ready=0.
REQ-027 SHALL ignore rd_ready outside READ.
REQ-028 A req_len of 2^LEN_WIDTH-1 (255) SHALL be supported with no gap cycles under continuous wr_valid or rd_ready.

Reset
REQ-029 When reset=1 on a rising edge, the state SHALL become IDLE and addr, remaining and pend SHALL become 0.
REQ-030 After such a reset edge, rd_data=0, rd_valid=0, done=0, err=0, busy=0, mem_cs=0, mem_we=0, mem_addr=0 and mem_data=Z.
REQ-031 Reset mid-burst SHALL abort the burst with no done pulse; any read in flight SHALL be discarded.
REQ-032 SHALL assert req_ready=1 in the first cycle after reset deasserts.

Verification
REQ-033 The bench SHALL cover: write, addr 0x40, len 3, wr_valid held high -> mem_addr 0x40, 0x60, 0x80 on 3 consecutive cycles with mem_we=1, done one cycle later.
REQ-034 The bench SHALL cover: read of the same region, rd_ready high -> rd_valid on 3 consecutive cycles, 1 cycle after each issue, data equal to the words written, done with the third rd_valid.
REQ-035 The bench SHALL cover: read, len 4, rd_ready toggled 1,0,1,1,0,1 -> exactly 4 issues at the rd_ready=1 cycles, 4 rd_valid pulses each one cycle later, addresses contiguous.
REQ-036 The bench SHALL cover: request with addr 0x44 or len 0 -> err pulse, no mem_cs, req_ready stays 1.
REQ-037 The bench SHALL cover: write, addr 0xFFFFFFE0, len 2 -> mem_addr 0xFFFFFFE0 then 0x00000000, done.
REQ-038 The bench SHALL cover: reset asserted after 2 of 5 read issues -> no further rd_valid or done, busy=0, next request accepted normally.
